// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: shared state codes, scan-code constants, event record and scan-code to ASCII mapping.
package ps2_kbd_pkg;

    typedef logic [1:0] hs_state_t;
    localparam hs_state_t HS_WAIT = 2'd0;
    localparam hs_state_t HS_ACK  = 2'd1;
    localparam hs_state_t HS_GAP  = 2'd2;

    typedef logic [1:0] dec_state_t;
    localparam dec_state_t DEC_BASE    = 2'd0;
    localparam dec_state_t DEC_EXT     = 2'd1;
    localparam dec_state_t DEC_BRK     = 2'd2;
    localparam dec_state_t DEC_EXT_BRK = 2'd3;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_AA     = 8'hAA;
    localparam logic [7:0] SC_FA     = 8'hFA;
    localparam logic [7:0] SC_EE     = 8'hEE;
    localparam logic [7:0] SC_FE     = 8'hFE;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
        logic [7:0] ascii;
    } kbd_evt_t;

    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift, input logic caps);
        logic [7:0] a;
        logic [7:0] s;
        a = 8'h00;
        s = 8'h00;
        case (code)
            8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
            8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
            8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
            8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
            8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
            8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
            8'h35: a = "y";  8'h1A: a = "z";
            8'h45: begin a = "0"; s = ")"; end
            8'h16: begin a = "1"; s = "!"; end
            8'h1E: begin a = "2"; s = "@"; end
            8'h26: begin a = "3"; s = "#"; end
            8'h25: begin a = "4"; s = "$"; end
            8'h2E: begin a = "5"; s = "%"; end
            8'h36: begin a = "6"; s = "^"; end
            8'h3D: begin a = "7"; s = "&"; end
            8'h3E: begin a = "8"; s = "*"; end
            8'h46: begin a = "9"; s = "("; end
            8'h29: a = 8'h20;
            8'h5A: a = 8'h0D;
            default: a = 8'h00;
        endcase
        if (a >= "a" && a <= "z")
            return (shift ^ caps) ? a - 8'h20 : a;
        return (shift && s != 8'h00) ? s : a;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: synchronous event FIFO with sticky overflow; head is forced to zero while empty.
module ps2_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             valid_o,
    output logic             overflow_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             ovf_q, full, do_pop, do_push;

    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign valid_o = cnt_q != '0;
    assign do_pop  = pop_i && valid_o;
    // A pop in the same cycle frees the slot the push is written into.
    assign do_push = push_i && (!full || do_pop);
    assign dout_o  = valid_o ? mem_q[rd_q] : '0;
    assign overflow_o = ovf_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop)
                rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (push_i && full && !do_pop)
                ovf_q <= 1'b1;
        end
    end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// ps2_kbd_decoder: PS/2 byte handshake, E0/F0 prefix decode, modifier/ASCII tracking, event FIFO, press counter.
// Optional macro KBD_TYPEMATIC_FILTER_EN drops auto-repeat makes of the currently held key.
module ps2_kbd_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int CNT_MAX    = 99
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [7:0]           rx_data,
    input  logic                 rx_ready,
    input  logic                 rx_overflow,
    output logic                 rx_nextdata_n,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [7:0]           evt_code,
    output logic                 evt_ext,
    output logic                 evt_break,
    output logic [7:0]           evt_ascii,
    output logic [CNT_WIDTH-1:0] press_cnt,
    output logic                 shift,
    output logic                 caps,
    output logic                 key_held,
    output logic                 fifo_overflow
);
    import ps2_kbd_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CMAX = CNT_WIDTH'(CNT_MAX);

    hs_state_t            hs_q, hs_d;
    dec_state_t           dec_q, dec_d;
    logic [7:0]           byte_q;
    logic                 lsh_q, rsh_q, caps_q, held_vld_q;
    logic [8:0]           held_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 ack, ign, is_ext, is_brk, pfx_e0, pfx_f0, emit, is_mod, same_key, rpt, push, key_make;
    kbd_evt_t             evt_d, head;

    assign ack      = hs_q == HS_ACK;
    assign hs_d     = hs_q == HS_WAIT ? (rx_ready ? HS_ACK : HS_WAIT) : ack ? HS_GAP : HS_WAIT;
    assign ign      = byte_q inside {SC_AA, SC_FA, SC_EE, SC_FE, SC_E1, 8'h00, 8'hFF};
    assign is_ext   = dec_q == DEC_EXT || dec_q == DEC_EXT_BRK;
    assign is_brk   = dec_q == DEC_BRK || dec_q == DEC_EXT_BRK;
    assign pfx_e0   = dec_q == DEC_BASE && byte_q == SC_E0;
    assign pfx_f0   = byte_q == SC_F0 && (dec_q == DEC_BASE || dec_q == DEC_EXT);
    assign emit     = ack && !rx_overflow && !ign && !pfx_e0 && !pfx_f0;
    assign dec_d    = rx_overflow ? DEC_BASE : !ack ? dec_q : pfx_e0 ? DEC_EXT :
                      pfx_f0 ? (dec_q == DEC_BASE ? DEC_BRK : DEC_EXT_BRK) : DEC_BASE;
    assign is_mod   = !is_ext && byte_q inside {SC_LSHIFT, SC_RSHIFT, SC_CAPS};
    assign same_key = held_vld_q && held_q == {is_ext, byte_q};
`ifdef KBD_TYPEMATIC_FILTER_EN
    assign rpt      = same_key && !is_brk;
`else
    assign rpt      = 1'b0;
`endif
    assign push     = emit && !rpt;
    assign key_make = push && !is_brk && !is_mod;

    // ASCII uses the modifier state from before this byte.
    assign evt_d.ext   = is_ext;
    assign evt_d.brk   = is_brk;
    assign evt_d.code  = byte_q;
    assign evt_d.ascii = is_ext ? 8'h00 : scan_to_ascii(byte_q, lsh_q | rsh_q, caps_q);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hs_q       <= HS_WAIT;
            dec_q      <= DEC_BASE;
            byte_q     <= '0;
            lsh_q      <= 1'b0;
            rsh_q      <= 1'b0;
            caps_q     <= 1'b0;
            held_vld_q <= 1'b0;
            held_q     <= '0;
            cnt_q      <= '0;
        end else begin
            hs_q  <= hs_d;
            dec_q <= dec_d;
            if (hs_q == HS_WAIT && rx_ready)
                byte_q <= rx_data;
            if (emit && is_mod && byte_q == SC_LSHIFT)
                lsh_q <= !is_brk;
            if (emit && is_mod && byte_q == SC_RSHIFT)
                rsh_q <= !is_brk;
            if (emit && is_mod && byte_q == SC_CAPS && !is_brk)
                caps_q <= !caps_q;
            if (key_make) begin
                held_vld_q <= 1'b1;
                held_q     <= {is_ext, byte_q};
                cnt_q      <= cnt_q == CMAX ? cnt_q : cnt_q + 1'b1;
            end else if (emit && is_brk && same_key) begin
                held_vld_q <= 1'b0;
            end
        end
    end

    ps2_evt_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(18)) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push_i     (push),
        .pop_i      (evt_ready),
        .din_i      (evt_d),
        .dout_o     (head),
        .valid_o    (evt_valid),
        .overflow_o (fifo_overflow)
    );

    assign rx_nextdata_n = !ack;
    assign evt_code      = head.code;
    assign evt_ext       = head.ext;
    assign evt_break     = head.brk;
    assign evt_ascii     = head.ascii;
    assign press_cnt     = cnt_q;
    assign shift         = lsh_q | rsh_q;
    assign caps          = caps_q;
    assign key_held      = held_vld_q;

endmodule
